// File: rtl/rtc_bus_responder_if.sv
// ---------------------------------------------------------------------------
// rtc_bus_responder_if
//   Control strobes of the multiplexed RTC parallel bus.
//   AD : 0 = address phase, 1 = data phase
//   CS : chip select, active-low
//   WR : write strobe, active-low
//   RD : read strobe, active-low
//   master : the RTC read/write controller (drives the strobes)
//   slave  : the chip end of the bus (rtc_bus_responder)
//   The bidirectional data bus dato is a direct inout port of the responder,
//   so its tri-state resolution happens on a plain net at the level above.
// ---------------------------------------------------------------------------
interface rtc_bus_responder_if;
  logic AD;
  logic CS;
  logic WR;
  logic RD;

  modport master (output AD, output CS, output WR, output RD);
  modport slave  (input  AD, input  CS, input  WR, input  RD);
endinterface

// File: rtl/rtc_bus_responder.sv
// ---------------------------------------------------------------------------
// rtc_bus_responder
//   Chip-side model of the multiplexed RTC bus. Decodes address/data phases,
//   serves a register map (32 bytes scratch RAM at 0x00-0x1F, BCD seconds,
//   minutes and hours at 0x21/0x22/0x23) and advances the time registers from
//   an internal prescaler.
//
// Ports
//   clk    in     system clock, rising edge
//   reset  in     asynchronous active-low reset
//   bus    slave  AD / CS / WR / RD strobes (rtc_bus_responder_if)
//   dato   inout  8-bit address/data bus, driven only in a read data phase
//   seg    out    BCD seconds (mirror of 0x21)
//   min    out    BCD minutes (mirror of 0x22)
//   hora   out    BCD hours   (mirror of 0x23)
//
// Parameter
//   TICKS_PER_SEC  clk cycles per one-second increment (>= 2)
// ---------------------------------------------------------------------------
module rtc_bus_responder #(
  parameter int TICKS_PER_SEC = 100000000
) (
  input  logic                 clk,
  input  logic                 reset,
  rtc_bus_responder_if.slave   bus,
  inout  wire  [7:0]           dato,
  output logic [7:0]           seg,
  output logic [7:0]           min,
  output logic [7:0]           hora
);

  localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;

  // -------------------------------------------------------------------------
  // Input synchronizers: _m = first stage, _s = second stage.
  // r_wr_d delays WR_s by one more cycle for rising-edge detection.
  // -------------------------------------------------------------------------
  logic [7:0] r_dato_m, r_dato_s;
  logic       r_ad_m,   r_ad_s;
  logic       r_cs_m,   r_cs_s;
  logic       r_wr_m,   r_wr_s, r_wr_d;
  logic       r_rd_m,   r_rd_s;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dato_m <= '0;
      r_dato_s <= '0;
      r_ad_m   <= 1'b0;
      r_ad_s   <= 1'b0;
      r_cs_m   <= 1'b1;
      r_cs_s   <= 1'b1;
      r_wr_m   <= 1'b1;
      r_wr_s   <= 1'b1;
      r_wr_d   <= 1'b1;
      r_rd_m   <= 1'b1;
      r_rd_s   <= 1'b1;
    end else begin
      r_dato_m <= dato;
      r_dato_s <= r_dato_m;
      r_ad_m   <= bus.AD;
      r_ad_s   <= r_ad_m;
      r_cs_m   <= bus.CS;
      r_cs_s   <= r_cs_m;
      r_wr_m   <= bus.WR;
      r_wr_s   <= r_wr_m;
      r_wr_d   <= r_wr_s;
      r_rd_m   <= bus.RD;
      r_rd_s   <= r_rd_m;
    end
  end

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [7:0]    r_addr;
  logic [8:0]    r_wr_buf;       // {AD, data} latched while WR is low
  logic          r_wr_valid;     // wr_buf holds a capture not yet committed
  logic [PW-1:0] r_presc;
  logic          r_tick;
  logic          r_pending;
  logic [7:0]    r_sec, r_min, r_hora;
  logic [7:0]    r_ram [32];

  // -------------------------------------------------------------------------
  // Write path decode
  // -------------------------------------------------------------------------
  logic w_capture;
  logic w_commit;
  logic w_data_commit;
  logic w_ram_we;
  logic w_time_we;

  assign w_capture     = ~r_cs_s & ~r_wr_s;
  // The valid flag keeps a WR pulse seen with CS high from re-committing
  // whatever an earlier transaction left in wr_buf.
  assign w_commit      = r_wr_s & ~r_wr_d & r_wr_valid;
  assign w_data_commit = w_commit & r_wr_buf[8];
  assign w_ram_we      = w_data_commit & (r_addr[7:5] == 3'b000);
  assign w_time_we     = w_data_commit &
                         ((r_addr == 8'h21) | (r_addr == 8'h22) | (r_addr == 8'h23));

  // -------------------------------------------------------------------------
  // BCD increment
  // -------------------------------------------------------------------------
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] >= 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  logic       w_sec_carry, w_min_carry;
  logic [7:0] w_sec_next, w_min_next, w_hora_next;
  logic       w_do_inc;

  always_comb begin
    w_sec_carry = (r_sec >= 8'h59);
    w_min_carry = (r_min >= 8'h59);
    w_sec_next  = w_sec_carry ? 8'h00 : bcd_inc(r_sec);
    w_min_next  = w_min_carry ? 8'h00 : bcd_inc(r_min);
    w_hora_next = (r_hora >= 8'h23) ? 8'h00 : bcd_inc(r_hora);
  end

  // Increments are only applied while no transaction is open; a tick that
  // arrives with CS_s low is parked in r_pending and applied on the first
  // cycle CS_s is high again.
  assign w_do_inc = r_cs_s & (r_tick | r_pending);

  // -------------------------------------------------------------------------
  // Sequential core
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr     <= '0;
      r_wr_buf   <= '0;
      r_wr_valid <= 1'b0;
      r_presc    <= '0;
      r_tick     <= 1'b0;
      r_pending  <= 1'b0;
      r_sec      <= '0;
      r_min      <= '0;
      r_hora     <= '0;
      for (int i = 0; i < 32; i++) r_ram[i] <= '0;
    end else begin
      // Prescaler; the tick is registered so the time registers move on the
      // edge after the wrap.
      if (r_presc == PW'(TICKS_PER_SEC - 1)) begin
        r_presc <= '0;
        r_tick  <= 1'b1;
      end else begin
        r_presc <= r_presc + PW'(1);
        r_tick  <= 1'b0;
      end

      if (w_capture) begin
        r_wr_buf   <= {r_ad_s, r_dato_s};
        r_wr_valid <= 1'b1;
      end else if (w_commit) begin
        r_wr_valid <= 1'b0;
      end

      if (w_commit && !r_wr_buf[8])
        r_addr <= r_wr_buf[7:0];

      if (w_ram_we)
        r_ram[r_addr[4:0]] <= r_wr_buf[7:0];

      // Only one tick can be parked; further ticks under CS are lost.
      if (r_cs_s)
        r_pending <= 1'b0;
      else if (r_tick)
        r_pending <= 1'b1;

      // A bus write to a time register overrides the whole increment of
      // that cycle, carries included.
      if (w_time_we) begin
        case (r_addr)
          8'h21:   r_sec  <= r_wr_buf[7:0];
          8'h22:   r_min  <= r_wr_buf[7:0];
          8'h23:   r_hora <= r_wr_buf[7:0];
          default: ;
        endcase
      end else if (w_do_inc) begin
        r_sec <= w_sec_next;
        if (w_sec_carry) begin
          r_min <= w_min_next;
          if (w_min_carry)
            r_hora <= w_hora_next;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Read path
  // -------------------------------------------------------------------------
  logic [7:0] w_rd_data;
  logic       w_dato_oe;

  always_comb begin
    w_rd_data = 8'h00;
    if (r_addr[7:5] == 3'b000)
      w_rd_data = r_ram[r_addr[4:0]];
    else if (r_addr == 8'h21)
      w_rd_data = r_sec;
    else if (r_addr == 8'h22)
      w_rd_data = r_min;
    else if (r_addr == 8'h23)
      w_rd_data = r_hora;
  end

  // Gated with reset so the bus is released the moment reset asserts.
  assign w_dato_oe = reset & ~r_cs_s & ~r_rd_s & r_ad_s;
  assign dato      = w_dato_oe ? w_rd_data : 8'bz;

  assign seg  = r_sec;
  assign min  = r_min;
  assign hora = r_hora;

endmodule

// File: tb/tb_rtc_bus_responder.sv
module tb_rtc_bus_responder;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tb_dato;
  logic       tb_oe;
  wire  [7:0] dato;
  logic [7:0] seg, min, hora;

  int n_tests = 0;
  int n_fail  = 0;

  rtc_bus_responder_if bus_if ();

  // Released bus floats to 0xFF through the pull-ups.
  for (genvar gi = 0; gi < 8; gi++) begin : g_pull
    pullup (dato[gi]);
  end

  assign dato = tb_oe ? tb_dato : 8'bz;

  always #5 clk = ~clk;

  rtc_bus_responder #(.TICKS_PER_SEC(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if),
    .dato  (dato),
    .seg   (seg),
    .min   (min),
    .hora  (hora)
  );

  // ---------------------------------------------------------------- helpers
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_low();
    bus_if.CS = 1'b0;
    step(2);
  endtask

  // WR low for 3 clocks, then high; AD/dato held 3 more clocks. With
  // drop_cs the chip select is released together with WR.
  task automatic wr_pulse(input logic ad, input logic [7:0] d, input logic drop_cs);
    $display("[TB] write AD=%0d data=%02h cs_release=%0d", ad, d, drop_cs);
    bus_if.AD = ad;
    tb_dato   = d;
    tb_oe     = 1'b1;
    bus_if.WR = 1'b0;
    step(3);
    bus_if.WR = 1'b1;
    if (drop_cs) bus_if.CS = 1'b1;
    step(3);
    tb_oe = 1'b0;
  endtask

  task automatic rd_on();
    bus_if.AD = 1'b1;
    bus_if.RD = 1'b0;
    step(3);
    $display("[TB] read dato=%02h", dato);
  endtask

  task automatic rd_off();
    bus_if.RD = 1'b1;
    step(3);
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    n_tests++;
    if (dato !== 8'hFF) begin
      n_fail++; $display("FAIL reset_dato: got %02h expected FF (released)", dato);
    end
    n_tests++;
    if ({hora, min, seg} !== 24'h000000) begin
      n_fail++; $display("FAIL reset_time: got %02h:%02h:%02h expected 00:00:00", hora, min, seg);
    end
    reset = 1'b1;
    step(4);
    n_tests++;
    if (seg !== 8'h00) begin
      n_fail++; $display("FAIL tick_before: seg=%02h expected 00", seg);
    end
    step(1);
    n_tests++;
    if (seg !== 8'h01) begin
      n_fail++; $display("FAIL tick_after_wrap: seg=%02h expected 01", seg);
    end
  endtask

  task automatic test_write_read();
    cs_low();
    wr_pulse(1'b0, 8'h22, 1'b0);
    // Data phase done by hand to observe the 3-edge write latency.
    bus_if.AD = 1'b1; tb_dato = 8'h37; tb_oe = 1'b1; bus_if.WR = 1'b0;
    step(3);
    bus_if.WR = 1'b1;
    step(2);
    n_tests++;
    if (min !== 8'h00) begin
      n_fail++; $display("FAIL wr_latency_early: min=%02h expected 00", min);
    end
    step(1);
    n_tests++;
    if (min !== 8'h37) begin
      n_fail++; $display("FAIL wr_latency_3rd_edge: min=%02h expected 37", min);
    end
    tb_oe = 1'b0;
    wr_pulse(1'b0, 8'h21, 1'b0);
    wr_pulse(1'b1, 8'h45, 1'b0);
    n_tests++;
    if (seg !== 8'h45) begin
      n_fail++; $display("FAIL seg_write: seg=%02h expected 45", seg);
    end
    rd_on();
    n_tests++;
    if (dato !== 8'h45) begin
      n_fail++; $display("FAIL read_seg: dato=%02h expected 45", dato);
    end
    rd_off();
    n_tests++;
    if (dato !== 8'hFF) begin
      n_fail++; $display("FAIL read_release: dato=%02h expected FF (released)", dato);
    end
    // RD with AD low must not drive the bus.
    bus_if.AD = 1'b0; bus_if.RD = 1'b0;
    step(3);
    n_tests++;
    if (dato !== 8'hFF) begin
      n_fail++; $display("FAIL rd_addr_phase: dato=%02h expected FF (released)", dato);
    end
    bus_if.RD = 1'b1;
    step(1);
    wr_pulse(1'b0, 8'h22, 1'b0);
    rd_on();
    n_tests++;
    if (dato !== 8'h37) begin
      n_fail++; $display("FAIL read_min: dato=%02h expected 37", dato);
    end
    rd_off();
    bus_if.CS = 1'b1;
    step(1);
  endtask

  task automatic test_ram();
    cs_low();
    wr_pulse(1'b0, 8'h10, 1'b0);
    wr_pulse(1'b1, 8'hA5, 1'b0);
    wr_pulse(1'b0, 8'h1F, 1'b0);
    wr_pulse(1'b1, 8'h3C, 1'b0);
    wr_pulse(1'b0, 8'h10, 1'b0);
    rd_on();
    n_tests++;
    if (dato !== 8'hA5) begin
      n_fail++; $display("FAIL ram_0x10: dato=%02h expected A5", dato);
    end
    rd_off();
    wr_pulse(1'b0, 8'h1F, 1'b0);
    rd_on();
    n_tests++;
    if (dato !== 8'h3C) begin
      n_fail++; $display("FAIL ram_0x1F: dato=%02h expected 3C", dato);
    end
    rd_off();
    wr_pulse(1'b0, 8'h30, 1'b0);
    rd_on();
    n_tests++;
    if (dato !== 8'h00) begin
      n_fail++; $display("FAIL unmapped_read: dato=%02h expected 00", dato);
    end
    rd_off();
    wr_pulse(1'b1, 8'h30, 1'b0);
    rd_on();
    n_tests++;
    if (dato !== 8'h00) begin
      n_fail++; $display("FAIL unmapped_write: dato=%02h expected 00", dato);
    end
    rd_off();
    wr_pulse(1'b0, 8'h10, 1'b0);
    bus_if.CS = 1'b1;
    step(3);
    // WR pulse with chip select high: must be ignored.
    wr_pulse(1'b1, 8'h77, 1'b0);
    cs_low();
    rd_on();
    n_tests++;
    if (dato !== 8'hA5) begin
      n_fail++; $display("FAIL wr_cs_high_ignored: dato=%02h expected A5", dato);
    end
    rd_off();
    bus_if.CS = 1'b1;
    step(1);
  endtask

  task automatic test_rollover();
    cs_low();
    wr_pulse(1'b0, 8'h23, 1'b0);
    wr_pulse(1'b1, 8'h23, 1'b0);
    wr_pulse(1'b0, 8'h22, 1'b0);
    wr_pulse(1'b1, 8'h59, 1'b0);
    wr_pulse(1'b0, 8'h21, 1'b0);
    wr_pulse(1'b1, 8'h59, 1'b0);
    bus_if.CS = 1'b1;
    step(2);
    n_tests++;
    if ({hora, min, seg} !== 24'h235959) begin
      n_fail++; $display("FAIL rollover_hold: got %02h:%02h:%02h expected 23:59:59", hora, min, seg);
    end
    step(1);
    n_tests++;
    if ({hora, min, seg} !== 24'h000000) begin
      n_fail++; $display("FAIL rollover_day: got %02h:%02h:%02h expected 00:00:00", hora, min, seg);
    end
    cs_low();
    wr_pulse(1'b0, 8'h21, 1'b0);
    wr_pulse(1'b1, 8'h09, 1'b0);
    bus_if.CS = 1'b1;
    step(3);
    n_tests++;
    if (seg !== 8'h10) begin
      n_fail++; $display("FAIL bcd_09: seg=%02h expected 10", seg);
    end
    cs_low();
    wr_pulse(1'b1, 8'h0A, 1'b0);
    bus_if.CS = 1'b1;
    step(3);
    n_tests++;
    if (seg !== 8'h10) begin
      n_fail++; $display("FAIL bcd_illegal_0A: seg=%02h expected 10", seg);
    end
    cs_low();
    wr_pulse(1'b0, 8'h22, 1'b0);
    wr_pulse(1'b1, 8'h59, 1'b0);
    wr_pulse(1'b0, 8'h23, 1'b0);
    wr_pulse(1'b1, 8'h09, 1'b0);
    wr_pulse(1'b0, 8'h21, 1'b0);
    wr_pulse(1'b1, 8'h59, 1'b0);
    bus_if.CS = 1'b1;
    step(3);
    n_tests++;
    if ({hora, min, seg} !== 24'h100000) begin
      n_fail++; $display("FAIL hour_carry: got %02h:%02h:%02h expected 10:00:00", hora, min, seg);
    end
  endtask

  task automatic test_hold_cs();
    cs_low();
    wr_pulse(1'b0, 8'h21, 1'b0);
    wr_pulse(1'b1, 8'h12, 1'b0);
    step(10);
    n_tests++;
    if (seg !== 8'h12) begin
      n_fail++; $display("FAIL hold_under_cs: seg=%02h expected 12", seg);
    end
    bus_if.CS = 1'b1;
    step(2);
    n_tests++;
    if (seg !== 8'h12) begin
      n_fail++; $display("FAIL hold_sync_delay: seg=%02h expected 12", seg);
    end
    step(1);
    n_tests++;
    if (seg !== 8'h13) begin
      n_fail++; $display("FAIL pending_single: seg=%02h expected 13", seg);
    end
  endtask

  task automatic test_write_vs_tick();
    cs_low();
    wr_pulse(1'b0, 8'h22, 1'b0);
    wr_pulse(1'b1, 8'h10, 1'b0);
    wr_pulse(1'b0, 8'h21, 1'b0);
    wr_pulse(1'b1, 8'h59, 1'b0);
    step(5);
    // CS released with WR: the commit lands on the same edge as the parked
    // increment, which must be dropped together with its minute carry.
    wr_pulse(1'b1, 8'h30, 1'b1);
    n_tests++;
    if (seg !== 8'h30) begin
      n_fail++; $display("FAIL write_wins_seg: seg=%02h expected 30", seg);
    end
    n_tests++;
    if (min !== 8'h10) begin
      n_fail++; $display("FAIL write_wins_no_carry: min=%02h expected 10", min);
    end
  endtask

  task automatic test_reset_mid_read();
    cs_low();
    wr_pulse(1'b0, 8'h21, 1'b0);
    wr_pulse(1'b1, 8'h45, 1'b0);
    rd_on();
    n_tests++;
    if (dato !== 8'h45) begin
      n_fail++; $display("FAIL pre_reset_read: dato=%02h expected 45", dato);
    end
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if (dato !== 8'hFF) begin
      n_fail++; $display("FAIL reset_release_bus: dato=%02h expected FF (released)", dato);
    end
    n_tests++;
    if (seg !== 8'h00) begin
      n_fail++; $display("FAIL reset_async_seg: seg=%02h expected 00", seg);
    end
    @(negedge clk);
    bus_if.RD = 1'b1;
    bus_if.AD = 1'b0;
    step(1);
    reset = 1'b1;
    n_tests++;
    if ({hora, min, seg} !== 24'h000000) begin
      n_fail++; $display("FAIL post_reset_time: got %02h:%02h:%02h expected 00:00:00", hora, min, seg);
    end
    wr_pulse(1'b0, 8'h21, 1'b0);
    rd_on();
    n_tests++;
    if (dato !== 8'h00) begin
      n_fail++; $display("FAIL post_reset_read_seg: dato=%02h expected 00", dato);
    end
    rd_off();
    wr_pulse(1'b0, 8'h10, 1'b0);
    rd_on();
    n_tests++;
    if (dato !== 8'h00) begin
      n_fail++; $display("FAIL post_reset_ram: dato=%02h expected 00", dato);
    end
    rd_off();
    bus_if.CS = 1'b1;
    step(2);
  endtask

  initial begin
    reset     = 1'b0;
    tb_oe     = 1'b0;
    tb_dato   = 8'h00;
    bus_if.AD = 1'b0;
    bus_if.CS = 1'b1;
    bus_if.WR = 1'b1;
    bus_if.RD = 1'b1;
    step(3);
    test_reset();
    test_write_read();
    test_ram();
    test_rollover();
    test_hold_cs();
    test_write_vs_tick();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rtc_bus_responder.md
# rtc_bus_responder

Behavioural-synthesizable responder for the multiplexed RTC parallel bus (dato/AD/CS/WR/RD), acting as the chip end of the bus that the RTC read/write controller drives. It decodes address and data phases, serves a small register map (BCD seconds/minutes/hours plus scratch RAM) and advances the time registers from an internal prescaler. It sits in the simulation and bring-up setup in place of the physical RTC, so the controller, PicoBlaze port logic and VGA path can be exercised end to end.

## Interface
- TICKS_PER_SEC, 100000000, clk cycles per one-second time increment (≥2)
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  asynchronous, active-low reset
- dato  inout  8  multiplexed address/data bus; driven only during read data phase, else high-Z
- AD  input  1  0 = address phase, 1 = data phase
- CS  input  1  chip select, active-low
- WR  input  1  write strobe, active-low
- RD  input  1  read strobe, active-low
- seg  output  8  current BCD seconds (mirror of reg 0x21)
- min  output  8  current BCD minutes (mirror of reg 0x22)
- hora  output  8  current BCD hours (mirror of reg 0x23)

## Operation
- Inputs dato, AD, CS, WR, RD pass through a 2-flop synchronizer (suffix _s = stage 2); a third flop WR_d holds previous WR_s.
- Write capture: each cycle with CS_s=0 and WR_s=0, latch {AD_s, dato_s} into wr_buf. On WR_s rising (WR_s=1, WR_d=0) commit wr_buf: AD=0 → addr ← data; AD=1 → write data to reg[addr]. A WR pulse with CS high is ignored.
- Register map: 0x00–0x1F scratch RAM (32×8); 0x21 seconds, 0x22 minutes, 0x23 hours; all other addresses read 0x00, writes discarded. addr is not auto-incremented.
- Read: dato_oe = CS_s=0 & RD_s=0 & AD_s=1; dato driven with reg[addr] (combinational from addr), else 'bz. RD asserted with AD=0 drives nothing.
- Prescaler counts 0..TICKS_PER_SEC-1; on wrap a tick is raised.
- Tick processing: if CS_s=0 (any transaction open), set pending=1 and defer; the deferred increment is applied on the first cycle with CS_s=1, pending cleared. At most one pending tick (second tick while pending is lost).
- Increment (BCD): units<9 → units+1; else units←0, tens+1. Seconds: value ≥0x59 → 0x00, carry to minutes; same for minutes; hours ≥0x23 → 0x00, no carry. Illegal BCD values follow the same rules (e.g. 0x0A units≥9 → 0x10).
- A write commit to 0x21–0x23 in the same cycle as an increment: the write wins for that register; the increment, including any carries, is discarded.
- Reset: addr=0x00, wr_buf=0, all regs and RAM 0x00, prescaler=0, pending=0, synchronizers to idle (CS/WR/RD=1), dato high-Z, seg/min/hora=0x00.

## Timing
- Write latency: register updates at 3rd clk edge after the WR rising edge at the pin (2 sync + edge detect); seg/min/hora reflect it the same edge.
- Read: dato driven from the 2nd clk edge after the last of CS/RD falling with AD high; released 2 edges after RD or CS rises. The controller must hold RD low ≥4 clk and sample dato no earlier than 3 clk after RD fall.
- Minimum strobe widths: WR low ≥3 clk; AD/dato stable from WR fall to 2 clk after WR rise.
- Tick-to-output: seg updates on the edge after prescaler wrap (if CS_s=1).
- Async reset mid-transaction: dato released immediately (combinational on reset), any partial write discarded.

## Test plan
- Address 0x21 (AD=0, WR pulse), data 0x45 (AD=1, WR pulse), then read with RD → dato=0x45, seg=0x45 three clocks after WR rise.
- RAM: write 0xA5 to 0x10, write 0x3C to 0x1F, read both → 0xA5, 0x3C; read 0x30 → 0x00; write 0x30 then re-read → 0x00.
- TICKS_PER_SEC=4, load hora/min/seg=0x23/0x59/0x59 → after next tick all 0x00; from 0x09 seconds → 0x10.
- Hold CS low across a tick wrap with seg=0x12 → seg stays 0x12 while CS low, becomes 0x13 one cycle after CS_s returns high; two wraps under CS → only +1.
- Write 0x30 to 0x21 coinciding with tick → seg=0x30 (no 0x31, no minute carry).
- Assert reset (low) while dato is driven during a read → dato high-Z immediately; after release all outputs 0x00, read of 0x21 → 0x00.
